// File: rtl/ddr_pkg.sv
// Shared arrow/score types for the step judging datapath.
package ddr_pkg;

    localparam int unsigned ARROW_LEFT  = 3;
    localparam int unsigned ARROW_DOWN  = 2;
    localparam int unsigned ARROW_UP    = 1;
    localparam int unsigned ARROW_RIGHT = 0;

    typedef logic [3:0]  arrow_mask_t;
    typedef logic [11:0] bcd3_t;

    localparam bcd3_t SCORE_MAX_BCD = 12'h999;

    // Number of arrows set in a mask (0..4).
    function automatic logic [2:0] popcount4(input arrow_mask_t m);
        popcount4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// One pad bit: 2-flop synchronizer, debounce counter, registered rising-edge pulse.
module button_conditioner #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pad,
    output logic o_press
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;
    logic          w_accept;

    // The DB_CYCLES-th consecutive differing sample flips the accepted level.
    assign w_accept = (r_sync2 != r_level) && (r_cnt == CW'(DB_CYCLES - 1));
    assign o_press  = r_press;

    // Bring the raw pad level into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pad;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive samples disagreeing with the accepted level; any agreement restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= w_accept & r_sync2;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/step_judge.sv
// Judges pad presses against the arrows due each beat; keeps BCD score and combo.
module step_judge
    import ddr_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned COMBO_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stepEn,
    input  logic [3:0]  actionStep,
    input  logic [3:0]  pads,
    output logic [11:0] score,
    output logic [7:0]  combo,
    output logic [3:0]  hitFlash,
    output logic        missPulse,
    output logic        wrongPulse
);

    arrow_mask_t w_press;
    arrow_mask_t w_pendNow;
    arrow_mask_t w_hitMask;
    arrow_mask_t w_wrongMask;
    arrow_mask_t w_pendAfter;
    logic        w_dirtyAfter;
    logic [2:0]  w_addN;
    bcd3_t       w_scoreNext;
    logic [7:0]  w_comboNext;

    logic        r_loadPending;
    arrow_mask_t r_pending;
    logic        r_beatDirty;
    logic        r_hasArrows;
    bcd3_t       r_score;
    logic [7:0]  r_combo;
    arrow_mask_t r_hitFlash;
    logic        r_missPulse;
    logic        r_wrongPulse;

    genvar g;
    for (g = 0; g < 4; g++) begin : g_pad
        button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond (
            .clk     (clk),
            .rst     (reset),
            .i_pad   (pads[g]),
            .o_press (w_press[g])
        );
    end

    assign score      = r_score;
    assign combo      = r_combo;
    assign hitFlash   = r_hitFlash;
    assign missPulse  = r_missPulse;
    assign wrongPulse = r_wrongPulse;

    // In the load cycle presses are judged against the incoming arrows so the
    // load and the judge share one datapath.
    always_comb begin
        w_pendNow    = r_loadPending ? actionStep : r_pending;
        w_hitMask    = w_press & w_pendNow;
        w_wrongMask  = w_press & ~w_pendNow;
        w_pendAfter  = w_pendNow & ~w_press;
        w_dirtyAfter = (r_loadPending ? 1'b0 : r_beatDirty) | (|w_wrongMask);
    end

    // Single-cycle BCD add of 0..4 with digit carries, saturating at 999.
    always_comb begin
        logic [4:0] v_ones;
        logic [4:0] v_tens;
        logic [4:0] v_hund;
        logic       v_c1;
        logic       v_c2;
        w_addN = popcount4(w_hitMask);
        v_ones = {1'b0, r_score[3:0]} + {2'b00, w_addN};
        v_c1   = 1'b0;
        if (v_ones > 5'd9) begin
            v_ones = v_ones - 5'd10;
            v_c1   = 1'b1;
        end
        v_tens = {1'b0, r_score[7:4]} + {4'b0000, v_c1};
        v_c2   = 1'b0;
        if (v_tens > 5'd9) begin
            v_tens = v_tens - 5'd10;
            v_c2   = 1'b1;
        end
        v_hund = {1'b0, r_score[11:8]} + {4'b0000, v_c2};
        if (v_hund > 5'd9) begin
            w_scoreNext = SCORE_MAX_BCD;
        end else begin
            w_scoreNext = {v_hund[3:0], v_tens[3:0], v_ones[3:0]};
        end
    end

    // Wrong presses break the combo at once; a close either misses or credits a clean beat.
    always_comb begin
        w_comboNext = r_combo;
        if (|w_wrongMask) begin
            w_comboNext = '0;
        end
        if (stepEn) begin
            if (|w_pendAfter) begin
                w_comboNext = '0;
            end else if (r_hasArrows && !w_dirtyAfter && (r_combo != 8'(COMBO_MAX))) begin
                w_comboNext = r_combo + 8'd1;
            end
        end
    end

    // Beat state: load after stepEn, judge every cycle, clear on close.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_loadPending <= 1'b0;
            r_pending     <= '0;
            r_beatDirty   <= 1'b0;
            r_hasArrows   <= 1'b0;
        end else begin
            r_loadPending <= stepEn;
            if (stepEn) begin
                r_pending   <= '0;
                r_beatDirty <= 1'b0;
                r_hasArrows <= 1'b0;
            end else begin
                r_pending   <= w_pendAfter;
                r_beatDirty <= w_dirtyAfter;
                if (r_loadPending) begin
                    r_hasArrows <= |actionStep;
                end
            end
        end
    end

    // Registered score, combo and one-cycle event pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_score      <= '0;
            r_combo      <= '0;
            r_hitFlash   <= '0;
            r_missPulse  <= 1'b0;
            r_wrongPulse <= 1'b0;
        end else begin
            r_score      <= w_scoreNext;
            r_combo      <= w_comboNext;
            r_hitFlash   <= w_hitMask;
            r_missPulse  <= stepEn & (|w_pendAfter);
            r_wrongPulse <= |w_wrongMask;
        end
    end

endmodule

// File: tb/tb_step_judge.sv
// Self-checking bench for step_judge: event scoreboard plus per-scenario score/combo checks.
module tb_step_judge;
    import ddr_pkg::*;

    localparam int unsigned DB   = 4;
    localparam int unsigned BEAT = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        stepEn;
    logic [3:0]  actionStep;
    logic [3:0]  pads;
    logic [11:0] score;
    logic [7:0]  combo;
    logic [3:0]  hitFlash;
    logic        missPulse;
    logic        wrongPulse;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_score = 0;
    int exp_combo = 0;

    // Expected events {hitFlash, missPulse, wrongPulse}, in order of occurrence.
    logic [5:0] exp_q[$];
    logic [5:0] mon_ev;
    logic [5:0] mon_exp;

    step_judge #(.DB_CYCLES(DB), .COMBO_MAX(255)) dut (
        .clk        (clk),
        .reset      (reset),
        .stepEn     (stepEn),
        .actionStep (actionStep),
        .pads       (pads),
        .score      (score),
        .combo      (combo),
        .hitFlash   (hitFlash),
        .missPulse  (missPulse),
        .wrongPulse (wrongPulse)
    );

    always #5 clk = ~clk;

    function automatic bcd3_t to_bcd(input int v);
        return bcd3_t'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    // Every nonzero output event is matched against the next expected one.
    always @(posedge clk) begin
        #1;
        mon_ev = {hitFlash, missPulse, wrongPulse};
        if (mon_ev != 6'b0) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event got hit=%b miss=%b wrong=%b, expected none at %0t",
                         hitFlash, missPulse, wrongPulse, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_ev !== mon_exp) begin
                    n_fail++;
                    $display("FAIL event got {hit,miss,wrong}=%b expected %b at %0t",
                             mon_ev, mon_exp, $time);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step(input logic [3:0] arrows);
        @(negedge clk);
        stepEn = 1'b1;
        @(negedge clk);
        stepEn     = 1'b0;
        actionStep = arrows;
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        pads = pads | mask;
        tick(hold);
        pads = pads & ~mask;
        tick(10);
    endtask

    task automatic run_clean_beat(input logic [3:0] arrows);
        step(arrows);
        exp_q.push_back({arrows, 2'b00});
        press(arrows, 10);
        tick(14);
        step(4'b0000);
        if (exp_score + $countones(arrows) > 999) exp_score = 999;
        else exp_score = exp_score + $countones(arrows);
        if (arrows != 4'b0000 && exp_combo < 255) exp_combo++;
        n_tests++;
        if (score !== to_bcd(exp_score)) begin
            n_fail++;
            $display("FAIL clean_beat_score got %h expected %h", score, to_bcd(exp_score));
        end
        n_tests++;
        if (combo !== 8'(exp_combo)) begin
            n_fail++;
            $display("FAIL clean_beat_combo got %0d expected %0d", combo, exp_combo);
        end
        tick(2);
    endtask

    task automatic test_reset;
        reset = 1'b1; stepEn = 1'b0; actionStep = 4'b0000; pads = 4'b0000;
        tick(3);
        n_tests++;
        if ({score, combo, hitFlash, missPulse, wrongPulse} !== 26'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got score=%h combo=%0d hit=%b miss=%b wrong=%b expected all 0",
                     score, combo, hitFlash, missPulse, wrongPulse);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_idle;
        for (int b = 0; b < 5; b++) begin
            step(4'b0000);
            tick(BEAT - 2);
            n_tests++;
            if (score !== 12'h000 || combo !== 8'd0) begin
                n_fail++;
                $display("FAIL idle_beat%0d got score=%h combo=%0d expected 000/0", b, score, combo);
            end
        end
    endtask

    task automatic test_two_hits;
        step(4'b1001);
        exp_q.push_back({4'b1000, 2'b00});
        press(4'b1000, 10);
        exp_q.push_back({4'b0001, 2'b00});
        press(4'b0001, 10);
        step(4'b0000);
        exp_score += 2;
        exp_combo += 1;
        n_tests++;
        if (combo !== 8'd1) begin
            n_fail++;
            $display("FAIL two_hits_combo got %0d expected 1", combo);
        end
        n_tests++;
        if (score !== 12'h002) begin
            n_fail++;
            $display("FAIL two_hits_score got %h expected 002", score);
        end
        tick(BEAT - 2);
    endtask

    task automatic test_miss;
        step(4'b0100);
        tick(BEAT - 4);
        exp_q.push_back(6'b000010);
        step(4'b0000);
        exp_combo = 0;
        n_tests++;
        if (combo !== 8'd0) begin
            n_fail++;
            $display("FAIL miss_combo got %0d expected 0", combo);
        end
        n_tests++;
        if (score !== to_bcd(exp_score)) begin
            n_fail++;
            $display("FAIL miss_score got %h expected %h", score, to_bcd(exp_score));
        end
        tick(4);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL miss_event_seen got %0d outstanding expected 0", exp_q.size());
        end
        tick(BEAT - 6);
    endtask

    task automatic test_wrong_press;
        run_clean_beat(4'b0010);
        step(4'b0010);
        exp_q.push_back({4'b0010, 2'b00});
        press(4'b0010, 10);
        exp_q.push_back(6'b000001);
        press(4'b0010, 10);
        n_tests++;
        if (combo !== 8'd0) begin
            n_fail++;
            $display("FAIL wrong_combo_immediate got %0d expected 0", combo);
        end
        step(4'b0000);
        exp_score += 1;
        exp_combo = 0;
        n_tests++;
        if (combo !== 8'd0 || score !== to_bcd(exp_score)) begin
            n_fail++;
            $display("FAIL wrong_close got combo=%0d score=%h expected 0/%h", combo, score, to_bcd(exp_score));
        end
        tick(BEAT - 2);
    endtask

    task automatic test_bounce;
        step(4'b0100);
        exp_q.push_back({4'b0100, 2'b00});
        for (int i = 0; i < 12; i++) begin
            pads[2] = ((i / 2) % 2 == 0);
            tick(1);
        end
        pads[2] = 1'b1;
        tick(10);
        pads[2] = 1'b0;
        tick(10);
        step(4'b0000);
        exp_score += 1;
        exp_combo += 1;
        n_tests++;
        if (combo !== 8'(exp_combo) || score !== to_bcd(exp_score)) begin
            n_fail++;
            $display("FAIL bounce_close got combo=%0d score=%h expected %0d/%h",
                     combo, score, exp_combo, to_bcd(exp_score));
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bounce_events got %0d outstanding expected 0", exp_q.size());
        end
        tick(BEAT - 2);
    endtask

    task automatic test_saturation;
        int r;
        logic [3:0] m;
        while (998 - exp_score >= 4) run_clean_beat(4'b1111);
        r = 998 - exp_score;
        if (r > 0) begin
            m = 4'((1 << r) - 1);
            run_clean_beat(m);
        end
        n_tests++;
        if (score !== 12'h998) begin
            n_fail++;
            $display("FAIL preload_score got %h expected 998", score);
        end
        for (int b = 0; b < 6; b++) run_clean_beat(4'b1111);
        n_tests++;
        if (score !== 12'h999) begin
            n_fail++;
            $display("FAIL score_saturate got %h expected 999", score);
        end
        n_tests++;
        if (combo !== 8'd255) begin
            n_fail++;
            $display("FAIL combo_saturate got %0d expected 255", combo);
        end
    endtask

    task automatic test_reset_mid_beat;
        step(4'b0011);
        tick(5);
        reset = 1'b1;
        #1;
        n_tests++;
        if ({score, combo, hitFlash, missPulse, wrongPulse} !== 26'b0) begin
            n_fail++;
            $display("FAIL midbeat_reset got score=%h combo=%0d hit=%b miss=%b wrong=%b expected all 0",
                     score, combo, hitFlash, missPulse, wrongPulse);
        end
        tick(2);
        reset = 1'b0;
        exp_score = 0;
        exp_combo = 0;
        tick(20);
        step(4'b0000);
        n_tests++;
        if (combo !== 8'd0 || score !== 12'h000) begin
            n_fail++;
            $display("FAIL post_reset_close got combo=%0d score=%h expected 0/000", combo, score);
        end
        tick(BEAT - 2);
        run_clean_beat(4'b0001);
    endtask

    initial begin
        test_reset;
        test_idle;
        test_two_hits;
        test_miss;
        test_wrong_press;
        test_bounce;
        test_saturation;
        test_reset_mid_beat;
        tick(5);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_events got %0d outstanding expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
